// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchroniser, shared sample-tick prescaler and
//               independent per-bit debounce counters for raw board switches.
//               Emits a clean level vector plus one-cycle rise/fall masks and
//               an any-change strobe, all aligned with the sw_db update.
//               Optional feature macro SW_DB_TOGGLE_EN adds sw_tog, a per-bit
//               latch that inverts on every debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg,
    output logic             tick
`ifdef SW_DB_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] sw_tog
`endif
);

    // A one-cycle prescaler still needs a 1-bit register to keep widths legal.
    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    logic [c_PRE_W-1:0] r_pre;
    logic [WIDTH-1:0]   w_commit;

    // Two-stage synchroniser; every decision downstream looks only at r_s2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    // Free-running prescaler; tick is registered so it lands one cycle after
    // the terminal count and is shared by every bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (r_pre == c_PRE_LAST);
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + c_PRE_ONE;
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_CNT_W-1:0] r_cnt;

            // The last qualifying tick of a disagreement run accepts the level.
            assign w_commit[i] = (r_s2[i] != sw_db[i]) && tick && (r_cnt == c_CNT_LAST);

            // Count disagreeing ticks; any cycle of agreement aborts the run,
            // and a commit returns the counter to zero so it never overflows.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (r_s2[i] == sw_db[i]) begin
                    r_cnt <= '0;
                end else if (tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    // Level update and edge masks share one edge so pulses coincide with the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
        end else begin
            sw_db   <= sw_db ^ w_commit;
            sw_rise <= w_commit & r_s2;
            sw_fall <= w_commit & ~r_s2;
            sw_chg  <= |w_commit;
        end
    end

`ifdef SW_DB_TOGGLE_EN
    // Latched on/off per bit, flipped by the registered rise pulse, so the new
    // value appears the cycle after sw_rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_tog <= '0;
        end else begin
            sw_tog <= sw_tog ^ sw_rise;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Directed self-checking bench for sw_debounce with TICK_DIV=4,
//               STABLE_TICKS=3. Inputs change on the falling edge, outputs are
//               sampled on the falling edge. Define SW_DB_TOGGLE_EN to also
//               exercise sw_tog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] sw_db;
    logic [15:0] sw_rise;
    logic [15:0] sw_fall;
    logic        sw_chg;
    logic        tick;
`ifdef SW_DB_TOGGLE_EN
    logic [15:0] sw_tog;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] tog_at_pulse = '0;

    sw_debounce #(
        .WIDTH        (16),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .sw_chg  (sw_chg),
        .tick    (tick)
`ifdef SW_DB_TOGGLE_EN
        ,
        .sw_tog  (sw_tog)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rise0"}, 32'(sw_rise), 32'h0);
        check({tag, "_fall0"}, 32'(sw_fall), 32'h0);
        check({tag, "_chg0"},  32'(sw_chg),  32'h0);
    endtask

    // Wait for sw_db to move, counting edges since the input was driven, then
    // check latency window, new level, masks, and that pulses last one cycle.
    task automatic wait_db(input logic [15:0] exp_db, input logic [15:0] exp_rise,
                           input logic [15:0] exp_fall, input int lo, input int hi,
                           input string tag);
        logic [15:0] old_db;
        int n;
        bit done;
        old_db = sw_db;
        n      = 0;
        done   = 0;
        while (!done && n < hi + 3) begin
            step();
            n++;
            if (sw_db !== old_db) done = 1;
            else check_quiet({tag, "_wait"});
        end
        check($sformatf("%s_latency(n=%0d,lo=%0d,hi=%0d)", tag, n, lo, hi),
              32'(n >= lo && n <= hi), 32'h1);
        check({tag, "_db"},   32'(sw_db),   32'(exp_db));
        check({tag, "_rise"}, 32'(sw_rise), 32'(exp_rise));
        check({tag, "_fall"}, 32'(sw_fall), 32'(exp_fall));
        check({tag, "_chg"},  32'(sw_chg),  32'h1);
`ifdef SW_DB_TOGGLE_EN
        tog_at_pulse = sw_tog;
`endif
        step();
        check_quiet({tag, "_after"});
        check({tag, "_db_hold"}, 32'(sw_db), 32'(exp_db));
    endtask

    initial begin
        int seen;
        int guard;

        // Reset held with all switches high: everything stays cleared.
        reset = 1'b1;
        sw    = 16'hFFFF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rst%0d_db", k),   32'(sw_db),   32'h0);
            check($sformatf("rst%0d_rise", k), 32'(sw_rise), 32'h0);
            check($sformatf("rst%0d_fall", k), 32'(sw_fall), 32'h0);
            check($sformatf("rst%0d_chg", k),  32'(sw_chg),  32'h0);
            check($sformatf("rst%0d_tick", k), 32'(tick),    32'h0);
        end

        // Tick phase after release: high after the 4th, 8th edge.
        reset = 1'b0;
        sw    = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("tick_e%0d", k), 32'(tick), 32'((k % 4) == 0));
            check($sformatf("idle_e%0d_db", k), 32'(sw_db), 32'h0);
        end

        // Clean press on bit 0.
        sw = 16'h0001;
        wait_db(16'h0001, 16'h0001, 16'h0000, 11, 14, "press");

        // Bounce on bit 3: 7 high, 1 low, then steady high.
        sw = 16'h0009;
        for (int k = 0; k < 7; k++) begin
            step();
            check_quiet($sformatf("bounce_hi%0d", k));
            check($sformatf("bounce_hi%0d_db", k), 32'(sw_db), 32'h0001);
        end
        sw = 16'h0001;
        step();
        check_quiet("bounce_lo");
        sw = 16'h0009;
        wait_db(16'h0009, 16'h0008, 16'h0000, 11, 14, "bounce");

        // Release bit 3.
        sw = 16'h0001;
        wait_db(16'h0001, 16'h0000, 16'h0008, 11, 14, "rel3");

        // Bit 0 falls and bit 15 rises on the same edge.
        sw = 16'h8000;
        wait_db(16'h8000, 16'h8000, 16'h0001, 11, 14, "simul");

        // Reset in the middle of a bit-5 count.
        sw = 16'h8020;
        step();
        check_quiet("mid_sync0");
        step();
        check_quiet("mid_sync1");
        seen  = 0;
        guard = 0;
        while (seen < 2 && guard < 20) begin
            if (tick) seen++;
            step();
            check_quiet($sformatf("mid_cnt%0d", guard));
            guard++;
        end
        check("mid_ticks_seen", 32'(seen), 32'h2);
        check("mid_db_pre", 32'(sw_db), 32'h8000);
        reset = 1'b1;
        step();
        check("midrst_db",   32'(sw_db),   32'h0);
        check("midrst_rise", 32'(sw_rise), 32'h0);
        check("midrst_fall", 32'(sw_fall), 32'h0);
        check("midrst_chg",  32'(sw_chg),  32'h0);
        check("midrst_tick", 32'(tick),    32'h0);
        reset = 1'b0;
        wait_db(16'h8020, 16'h8020, 16'h0000, 13, 13, "mid_reset");

`ifdef SW_DB_TOGGLE_EN
        // Three press/release cycles on bit 0; only presses flip sw_tog[0].
        for (int p = 0; p < 3; p++) begin
            sw = 16'h8021;
            wait_db(16'h8021, 16'h0001, 16'h0000, 11, 14, $sformatf("tog_press%0d", p));
            check($sformatf("tog%0d_at_pulse", p), 32'(tog_at_pulse[0]), 32'(p % 2));
            check($sformatf("tog%0d_after", p),    32'(sw_tog[0]),       32'((p + 1) % 2));
            sw = 16'h8020;
            wait_db(16'h8020, 16'h0000, 16'h0001, 11, 14, $sformatf("tog_rel%0d", p));
            check($sformatf("tog%0d_rel", p), 32'(sw_tog[0]), 32'((p + 1) % 2));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
